// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bubble insert, flush and stall counter; 1-cycle latency, no in->out comb path.
// SKID=0: one entry, in_ready passes out_ready through; SKID=1: two-entry skid, in_ready from a register.
module pipe_stage_reg #(
  parameter int                DATA_W    = 128,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = '1,
  parameter bit                SKID      = 1'b0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              rdy_q;
  logic              space;
  logic              take;
  logic              out_xfer;
  logic [CTRL_W-1:0] new_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // A bubble uses the same space as a real entry but never consumes in_data.
  always_comb begin
    space = 1'b0;
    if (SKID) space = rdy_q;
    else      space = (state == ST_EMPTY) || out_ready;
  end

  assign in_ready  = space && !(bubble && in_valid) && (SKID ? reset : 1'b1);
  assign take      = in_valid && space && !flush;
  assign out_valid = (state != ST_EMPTY);
  assign out_xfer  = out_valid && out_ready;
  assign new_ctrl  = bubble ? (in_ctrl & ~KILL_MASK) : in_ctrl;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (take) state_nxt = ST_ONE;
        ST_ONE: begin
          if (out_xfer && !take)      state_nxt = ST_EMPTY;
          else if (take && !out_xfer) state_nxt = ST_TWO;
        end
        ST_TWO:   if (out_xfer) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      rdy_q     <= 1'b1;
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != ST_TWO);
      if (!flush) begin
        if (take && ((state == ST_EMPTY) || ((state == ST_ONE) && out_xfer))) begin
          head_data <= in_data;
          head_ctrl <= new_ctrl;
        end else if ((state == ST_TWO) && out_xfer) begin
          head_data <= skid_data;
          head_ctrl <= skid_ctrl;
        end
        if (take && (state == ST_ONE) && !out_xfer) begin
          skid_data <= in_data;
          skid_ctrl <= new_ctrl;
        end
      end
    end
  end

  // Counts backpressure seen by the head; a flush does not clear it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_data  = head_data;
  assign out_ctrl  = out_valid ? head_ctrl : (head_ctrl & ~KILL_MASK);
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg: SKID=0, SKID=1 and a narrow-counter SKID=0 instance share inputs.
module tb_pipe_stage_reg;

  typedef struct {
    int          dut;
    logic        rst, iv;
    logic [15:0] d, c;
    logic        bub, fl, ord;
    logic        ir, ov;
    logic [15:0] od, oc;
    logic [1:0]  occ;
    logic [15:0] st;
  } vec_t;

  logic        clk;
  logic        reset, in_valid, bubble, flush, out_ready;
  logic [15:0] in_data, in_ctrl;
  logic        ir_a  [3];
  logic        ov_a  [3];
  logic [15:0] od_a  [3];
  logic [15:0] oc_a  [3];
  logic [1:0]  occ_a [3];
  logic [15:0] st0, st1;
  logic [1:0]  st2;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .KILL_MASK(16'h00F0), .SKID(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov_a[0]), .out_ready(out_ready),
    .out_data(od_a[0]), .out_ctrl(oc_a[0]), .occupancy(occ_a[0]), .stall_cnt(st0));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .KILL_MASK(16'h00F0), .SKID(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov_a[1]), .out_ready(out_ready),
    .out_data(od_a[1]), .out_ctrl(oc_a[1]), .occupancy(occ_a[1]), .stall_cnt(st1));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .SKID(1'b0), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a[2]), .in_data(in_data),
    .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush), .out_valid(ov_a[2]), .out_ready(out_ready),
    .out_data(od_a[2]), .out_ctrl(oc_a[2]), .occupancy(occ_a[2]), .stall_cnt(st2));

  function automatic vec_t mk(int dut, logic rst, logic iv, logic [15:0] d, logic [15:0] c,
                              logic bub, logic fl, logic ord, logic ir, logic ov,
                              logic [15:0] od, logic [15:0] oc, logic [1:0] occ, logic [15:0] st);
    vec_t v;
    v.dut = dut; v.rst = rst; v.iv = iv; v.d = d; v.c = c; v.bub = bub; v.fl = fl; v.ord = ord;
    v.ir = ir; v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.st = st;
    return v;
  endfunction

  // Reset edge: every output returns to zero; SKID=1 holds in_ready low.
  function automatic vec_t rst_v(int dut);
    return mk(dut, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, (dut != 1), 1'b0, 16'h0, 16'h0, 2'd0, 16'h0);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d, dut u%0d): got %h, expected %h", nm, idx, tbl.size() > 0 ? 0 : 0, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [15:0] st_a;
    reset = v.rst; in_valid = v.iv; in_data = v.d; in_ctrl = v.c;
    bubble = v.bub; flush = v.fl; out_ready = v.ord;
    n_vec++;
    #1;
    chk("in_ready", idx, {15'd0, ir_a[v.dut]}, {15'd0, v.ir});
    @(posedge clk);
    #1;
    st_a = (v.dut == 0) ? st0 : (v.dut == 1) ? st1 : {14'd0, st2};
    chk("out_valid", idx, {15'd0, ov_a[v.dut]}, {15'd0, v.ov});
    chk("out_data", idx, od_a[v.dut], v.od);
    chk("out_ctrl", idx, oc_a[v.dut], v.oc);
    chk("occupancy", idx, {14'd0, occ_a[v.dut]}, {14'd0, v.occ});
    chk("stall_cnt", idx, st_a, v.st);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;

    for (int k = 0; k < 3; k++) tbl.push_back(rst_v(k));
    // SKID=0 streaming 1..8, then drain; idle ctrl shows killed bits as 0
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 1, 1, 16'(i), 16'h1234, 0, 0, 1, 1, 1, 16'(i), 16'h1234, 2'd1, 16'h0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h1234, 0, 0, 1, 1, 0, 16'h0008, 16'h1204, 2'd0, 16'h0));
    // SKID=0 backpressure passes straight through, then same-cycle replace
    tbl.push_back(rst_v(0));
    tbl.push_back(mk(0, 1, 1, 16'h21, 16'h1234, 0, 0, 0, 1, 1, 16'h21, 16'h1234, 2'd1, 16'h0));
    tbl.push_back(mk(0, 1, 1, 16'h22, 16'h1234, 0, 0, 0, 0, 1, 16'h21, 16'h1234, 2'd1, 16'h1));
    tbl.push_back(mk(0, 1, 1, 16'h22, 16'h1234, 0, 0, 1, 1, 1, 16'h22, 16'h1234, 2'd1, 16'h1));
    // SKID=1 fill to TWO under 3 stalled cycles, then drain in order
    tbl.push_back(rst_v(1));
    tbl.push_back(mk(1, 1, 1, 16'h11, 16'h00AA, 0, 0, 1, 1, 1, 16'h11, 16'h00AA, 2'd1, 16'h0));
    tbl.push_back(mk(1, 1, 1, 16'h22, 16'h00AA, 0, 0, 0, 1, 1, 16'h11, 16'h00AA, 2'd2, 16'h1));
    tbl.push_back(mk(1, 1, 1, 16'h33, 16'h00AA, 0, 0, 0, 0, 1, 16'h11, 16'h00AA, 2'd2, 16'h2));
    tbl.push_back(mk(1, 1, 1, 16'h33, 16'h00AA, 0, 0, 0, 0, 1, 16'h11, 16'h00AA, 2'd2, 16'h3));
    tbl.push_back(mk(1, 1, 1, 16'h33, 16'h00AA, 0, 0, 1, 0, 1, 16'h22, 16'h00AA, 2'd1, 16'h3));
    tbl.push_back(mk(1, 1, 1, 16'h33, 16'h00AA, 0, 0, 1, 1, 1, 16'h33, 16'h00AA, 2'd1, 16'h3));
    tbl.push_back(mk(1, 1, 0, 16'h33, 16'h00AA, 0, 0, 1, 1, 0, 16'h33, 16'h000A, 2'd0, 16'h3));
    // bubble loads a killed copy, the real entry follows; bubble without valid is ignored
    tbl.push_back(rst_v(1));
    tbl.push_back(mk(1, 1, 1, 16'h55, 16'hFFFF, 1, 0, 1, 0, 1, 16'h55, 16'hFF0F, 2'd1, 16'h0));
    tbl.push_back(mk(1, 1, 1, 16'h55, 16'hFFFF, 0, 0, 1, 1, 1, 16'h55, 16'hFFFF, 2'd1, 16'h0));
    tbl.push_back(mk(1, 1, 0, 16'h66, 16'hFFFF, 1, 0, 1, 1, 0, 16'h55, 16'hFF0F, 2'd0, 16'h0));
    // flush in TWO and in ONE drops held and same-cycle entries; stall_cnt keeps counting
    tbl.push_back(rst_v(1));
    tbl.push_back(mk(1, 1, 1, 16'h0A, 16'h0001, 0, 0, 0, 1, 1, 16'h0A, 16'h0001, 2'd1, 16'h0));
    tbl.push_back(mk(1, 1, 1, 16'h0B, 16'h0001, 0, 0, 0, 1, 1, 16'h0A, 16'h0001, 2'd2, 16'h1));
    tbl.push_back(mk(1, 1, 1, 16'h0C, 16'h0001, 0, 1, 0, 0, 0, 16'h0A, 16'h0001, 2'd0, 16'h2));
    tbl.push_back(mk(1, 1, 1, 16'h0D, 16'h0001, 0, 0, 1, 1, 1, 16'h0D, 16'h0001, 2'd1, 16'h2));
    tbl.push_back(mk(1, 1, 1, 16'h0E, 16'h0001, 0, 1, 0, 1, 0, 16'h0D, 16'h0001, 2'd0, 16'h3));
    tbl.push_back(mk(1, 1, 0, 16'h0E, 16'h0001, 0, 0, 1, 1, 0, 16'h0D, 16'h0001, 2'd0, 16'h3));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset while holding two entries with stall_cnt=5, then accept on the first edge after reset
    apply(rst_v(1), 100);
    apply(mk(1, 1, 1, 16'h31, 16'h00AA, 0, 0, 1, 1, 1, 16'h31, 16'h00AA, 2'd1, 16'h0), 101);
    apply(mk(1, 1, 1, 16'h32, 16'h00AA, 0, 0, 0, 1, 1, 16'h31, 16'h00AA, 2'd2, 16'h1), 102);
    for (int i = 2; i <= 5; i++)
      apply(mk(1, 1, 0, 16'h0, 16'h00AA, 0, 0, 0, 0, 1, 16'h31, 16'h00AA, 2'd2, 16'(i)), 101 + i);
    apply(rst_v(1), 107);
    apply(mk(1, 1, 1, 16'h40, 16'h00AA, 0, 0, 1, 1, 1, 16'h40, 16'h00AA, 2'd1, 16'h0), 108);

    // 2-bit stall counter saturates at 3
    apply(rst_v(2), 200);
    apply(mk(2, 1, 1, 16'h77, 16'h1234, 0, 0, 1, 1, 1, 16'h77, 16'h1234, 2'd1, 16'h0), 201);
    for (int i = 1; i <= 6; i++)
      apply(mk(2, 1, 0, 16'h0, 16'h1234, 0, 0, 0, 0, 1, 16'h77, 16'h1234, 2'd1, (i > 3) ? 16'h3 : 16'(i)), 201 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128: width of the datapath payload (operands, immediate, pc_next).
REQ-002 Parameter CTRL_W, default 16: width of the control payload (EX/MEM/WB control fields).
REQ-003 Parameter KILL_MASK, CTRL_W bits, default all ones: control bits forced to 0 in a bubble entry, e.g. RegWrite/MemRead/MemWrite.
REQ-004 Parameter SKID, default 0: selects the buffering mode; 0 = single register, 1 = two-entry skid buffer.
REQ-005 Parameter CNT_W, default 16: width of the stall counter.
REQ-006 clk  input  1  clock; all state updates occur on the rising edge.
REQ-007 reset  input  1  reset, synchronous, active-low.
REQ-008 in_valid  input  1  upstream stage presents an entry.
REQ-009 in_ready  output  1  stage accepts the entry this cycle.
REQ-010 in_data  input  DATA_W  upstream datapath payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control payload.
REQ-012 bubble  input  1  hazard unit request to insert a killed entry in place of the input.
REQ-013 flush  input  1  discard all held entries (branch/jump redirect).
REQ-014 out_valid  output  1  head entry valid.
REQ-015 out_ready  input  1  downstream accepts the head entry.
REQ-016 out_data  output  DATA_W  head datapath payload.
REQ-017 out_ctrl  output  CTRL_W  head control payload.
REQ-018 occupancy  output  2  number of held entries (0..1 when SKID=0, 0..2 when SKID=1).
REQ-019 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-020 An input transfer occurs on an edge where in_valid=1 and in_ready=1; an output transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-021 When SKID=0, the block has states EMPTY and FULL, and in_ready = (state==EMPTY) or out_ready (combinational pass-through of backpressure).
REQ-022 When SKID=0, simultaneous input and output transfers in FULL replace the entry with zero bubble cycles, sustaining 1 entry/cycle.
REQ-023 When SKID=1, the block has states EMPTY, ONE and TWO, and in_ready = (state!=TWO), driven from a register with no combinational path from out_ready.
REQ-024 SKID=1 transitions: EMPTY->ONE on input; ONE->TWO on input without output; TWO->ONE on output; ONE->EMPTY on output without input; ONE holds on simultaneous input and output.
REQ-025 Entries leave in FIFO order, and out_data/out_ctrl always reflect the oldest entry.
REQ-026 Latency: an entry accepted on edge N appears at the outputs after edge N when the block was empty; there is no combinational in->out data path.
REQ-027 bubble=1 with in_valid=1 forces in_ready=0 for that cycle: in_data is not consumed, and a bubble entry is loaded instead when space exists (same space rule as a normal input).
REQ-028 A bubble entry has data = in_data, ctrl = in_ctrl & ~KILL_MASK, and out_valid=1.
REQ-029 bubble=1 with in_valid=0 has no effect.
REQ-030 flush=1 on an edge empties the block (occupancy 0, out_valid 0) and discards any same-cycle input or bubble; in_ready keeps its normal value.
REQ-031 Precedence on an edge: reset > flush > bubble > normal transfer.
REQ-032 stall_cnt increments on each edge with out_valid=1 and out_ready=0, saturates at all ones, and is unaffected by flush.
REQ-033 While out_valid=0, out_data and out_ctrl hold their last value, but out_ctrl bits selected by KILL_MASK read 0.

Reset
REQ-034 On an edge with reset=0: state EMPTY, occupancy 0, out_valid 0, out_data 0, out_ctrl 0, stall_cnt 0.
REQ-035 During reset, in_ready reads 0 when SKID=1 and follows REQ-021 when SKID=0; reset in mid-operation discards all held entries.
REQ-036 The first input is accepted on the first edge after reset returns to 1.

Verification
REQ-037 SKID=0, streaming with out_ready=1: 8 back-to-back inputs 0x1..0x8 -> outputs 0x1..0x8 one per cycle, 1-cycle latency, in_ready constantly 1.
REQ-038 SKID=1, out_ready low for 3 cycles with in_valid=1: two entries accepted, in_ready=0 in TWO, stall_cnt=3; on out_ready=1 they drain in order with no loss or duplication.
REQ-039 bubble=1 for 1 cycle with in_ctrl=0xFFFF, KILL_MASK=0x00F0: out_ctrl=0xFF0F with out_valid=1, in_ready=0 that cycle, and the same input is accepted the next cycle.
REQ-040 flush=1 in state TWO with in_valid=1: occupancy=0 and out_valid=0 next cycle, and the same-cycle input never appears on the outputs.
REQ-041 reset=0 asserted while occupancy=2 and stall_cnt=5: all outputs take their REQ-034 values after one edge.
REQ-042 CNT_W=2, out_valid=1 with out_ready=0 for 6 cycles: stall_cnt saturates at 3.
